// File: rtl/matrix3_band_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matrix3_band_sequencer
// Purpose  : Fills one 4-row band of the 640x4 3x3-matrix frame buffer from
//            a raster pixel stream, then scans that band. Each pixel's
//            8-neighbour matrix is presented downstream with a valid/ready
//            handshake. The block alternates fill and scan, one band at a time.
// Ports    : I_CLK, I_RESET_N (async, active low)
//            I_PIXEL / I_PIXEL_VALID / O_PIXEL_READY   upstream stream
//            O_BUF_COLUMN / O_BUF_ROW / O_BUF_PIXEL    buffer address + data
//            O_BUF_WRITE_ENABLE / O_BUF_READ_ENABLE    buffer strobes
//            I_BUF_MATRIX                              buffer matrix output
//            O_MATRIX / O_MATRIX_ROW / O_MATRIX_COLUMN downstream matrix
//            O_MATRIX_VALID / I_MATRIX_READY           downstream handshake
//            O_BAND_DONE                               last matrix accepted
// Revision : 1.0 - initial release
// ============================================================================
module matrix3_band_sequencer #(
  parameter int P_COLUMNS     = 640,
  parameter int P_ROWS        = 4,
  parameter int P_PIXEL_DEPTH = 8
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET_N,
  input  logic [P_PIXEL_DEPTH-1:0]       I_PIXEL,
  input  logic                           I_PIXEL_VALID,
  output logic                           O_PIXEL_READY,
  output logic [$clog2(P_COLUMNS)-1:0]   O_BUF_COLUMN,
  output logic [$clog2(P_ROWS)-1:0]      O_BUF_ROW,
  output logic [P_PIXEL_DEPTH-1:0]       O_BUF_PIXEL,
  output logic                           O_BUF_WRITE_ENABLE,
  output logic                           O_BUF_READ_ENABLE,
  input  logic [8*P_PIXEL_DEPTH-1:0]     I_BUF_MATRIX,
  output logic [8*P_PIXEL_DEPTH-1:0]     O_MATRIX,
  output logic [$clog2(P_ROWS)-1:0]      O_MATRIX_ROW,
  output logic [$clog2(P_COLUMNS)-1:0]   O_MATRIX_COLUMN,
  output logic                           O_MATRIX_VALID,
  input  logic                           I_MATRIX_READY,
  output logic                           O_BAND_DONE
);

  localparam int c_COL_W = $clog2(P_COLUMNS);
  localparam int c_ROW_W = $clog2(P_ROWS);
  localparam int c_MAT_W = 8 * P_PIXEL_DEPTH;
  localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(P_COLUMNS - 1);
  localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(P_ROWS - 1);

  typedef enum logic [2:0] {
    S_FILL     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_RD_LATCH = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t r_state, w_state_next;

  // Registered outputs and pointers
  logic                     r_pixel_ready,  w_pixel_ready_next;
  logic [c_COL_W-1:0]       r_buf_col,      w_buf_col_next;
  logic [c_ROW_W-1:0]       r_buf_row,      w_buf_row_next;
  logic [P_PIXEL_DEPTH-1:0] r_buf_pixel,    w_buf_pixel_next;
  logic                     r_buf_we,       w_buf_we_next;
  logic                     r_buf_re,       w_buf_re_next;
  logic [c_MAT_W-1:0]       r_matrix,       w_matrix_next;
  logic [c_ROW_W-1:0]       r_mat_row,      w_mat_row_next;
  logic [c_COL_W-1:0]       r_mat_col,      w_mat_col_next;
  logic                     r_mat_valid,    w_mat_valid_next;
  logic                     r_band_done,    w_band_done_next;
  logic [c_ROW_W-1:0]       r_wr_row,       w_wr_row_next;
  logic [c_COL_W-1:0]       r_wr_col,       w_wr_col_next;
  logic [c_ROW_W-1:0]       r_sc_row,       w_sc_row_next;
  logic [c_COL_W-1:0]       r_sc_col,       w_sc_col_next;

  logic w_accept;
  logic w_handshake;
  logic w_wr_last_col;
  logic w_sc_last_col;

  // Ready is only ever high in FILL, so the accept needs no state qualifier.
  assign w_accept      = I_PIXEL_VALID & r_pixel_ready;
  assign w_handshake   = r_mat_valid & I_MATRIX_READY;
  assign w_wr_last_col = (r_wr_col == c_LAST_COL);
  assign w_sc_last_col = (r_sc_col == c_LAST_COL);

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pixel_ready_next = r_pixel_ready;
    w_buf_col_next     = r_buf_col;
    w_buf_row_next     = r_buf_row;
    w_buf_pixel_next   = r_buf_pixel;
    w_buf_we_next      = 1'b0;
    w_buf_re_next      = 1'b0;
    w_matrix_next      = r_matrix;
    w_mat_row_next     = r_mat_row;
    w_mat_col_next     = r_mat_col;
    w_mat_valid_next   = r_mat_valid;
    w_band_done_next   = 1'b0;
    w_wr_row_next      = r_wr_row;
    w_wr_col_next      = r_wr_col;
    w_sc_row_next      = r_sc_row;
    w_sc_col_next      = r_sc_col;

    case (r_state)
      S_FILL: begin
        // Ready comes up on the first edge after reset and stays up
        // until the final pixel of the band is taken.
        w_pixel_ready_next = 1'b1;
        if (w_accept) begin
          w_buf_we_next    = 1'b1;
          w_buf_pixel_next = I_PIXEL;
          w_buf_row_next   = r_wr_row;
          w_buf_col_next   = r_wr_col;
          if (w_wr_last_col && (r_wr_row == c_LAST_ROW)) begin
            w_pixel_ready_next = 1'b0;
            w_wr_row_next      = '0;
            w_wr_col_next      = '0;
            w_state_next       = S_RD_ISSUE;
          end else if (w_wr_last_col) begin
            w_wr_col_next = '0;
            w_wr_row_next = r_wr_row + 1'b1;
          end else begin
            w_wr_col_next = r_wr_col + 1'b1;
          end
        end
      end

      S_RD_ISSUE: begin
        w_buf_re_next  = 1'b1;
        w_buf_row_next = r_sc_row;
        w_buf_col_next = r_sc_col;
        w_state_next   = S_RD_WAIT;
      end

      // Read strobe is on the bus this cycle; the buffer registers the
      // matrix at the end of it.
      S_RD_WAIT: begin
        w_state_next = S_RD_LATCH;
      end

      S_RD_LATCH: begin
        w_matrix_next    = I_BUF_MATRIX;
        w_mat_row_next   = r_sc_row;
        w_mat_col_next   = r_sc_col;
        w_mat_valid_next = 1'b1;
        w_state_next     = S_HOLD;
      end

      S_HOLD: begin
        if (w_handshake) begin
          w_mat_valid_next = 1'b0;
          if (w_sc_last_col && (r_sc_row == c_LAST_ROW)) begin
            w_band_done_next   = 1'b1;
            w_pixel_ready_next = 1'b1;
            w_sc_row_next      = '0;
            w_sc_col_next      = '0;
            w_state_next       = S_FILL;
          end else begin
            if (w_sc_last_col) begin
              w_sc_col_next = '0;
              w_sc_row_next = r_sc_row + 1'b1;
            end else begin
              w_sc_col_next = r_sc_col + 1'b1;
            end
            w_state_next = S_RD_ISSUE;
          end
        end
      end

      default: begin
        w_state_next = S_FILL;
      end
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_pixel_ready <= 1'b0;
      r_buf_col     <= '0;
      r_buf_row     <= '0;
      r_buf_pixel   <= '0;
      r_buf_we      <= 1'b0;
      r_buf_re      <= 1'b0;
      r_matrix      <= '0;
      r_mat_row     <= '0;
      r_mat_col     <= '0;
      r_mat_valid   <= 1'b0;
      r_band_done   <= 1'b0;
      r_wr_row      <= '0;
      r_wr_col      <= '0;
      r_sc_row      <= '0;
      r_sc_col      <= '0;
    end else begin
      r_pixel_ready <= w_pixel_ready_next;
      r_buf_col     <= w_buf_col_next;
      r_buf_row     <= w_buf_row_next;
      r_buf_pixel   <= w_buf_pixel_next;
      r_buf_we      <= w_buf_we_next;
      r_buf_re      <= w_buf_re_next;
      r_matrix      <= w_matrix_next;
      r_mat_row     <= w_mat_row_next;
      r_mat_col     <= w_mat_col_next;
      r_mat_valid   <= w_mat_valid_next;
      r_band_done   <= w_band_done_next;
      r_wr_row      <= w_wr_row_next;
      r_wr_col      <= w_wr_col_next;
      r_sc_row      <= w_sc_row_next;
      r_sc_col      <= w_sc_col_next;
    end
  end

  assign O_PIXEL_READY      = r_pixel_ready;
  assign O_BUF_COLUMN       = r_buf_col;
  assign O_BUF_ROW          = r_buf_row;
  assign O_BUF_PIXEL        = r_buf_pixel;
  assign O_BUF_WRITE_ENABLE = r_buf_we;
  assign O_BUF_READ_ENABLE  = r_buf_re;
  assign O_MATRIX           = r_matrix;
  assign O_MATRIX_ROW       = r_mat_row;
  assign O_MATRIX_COLUMN    = r_mat_col;
  assign O_MATRIX_VALID     = r_mat_valid;
  assign O_BAND_DONE        = r_band_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix3_band_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix3_band_sequencer
// Purpose  : Self-checking bench for matrix3_band_sequencer. Contains a
//            behavioural model of the 640x4 matrix buffer, a driver that
//            fills bands, and a scoreboard monitor checking write/read
//            strobes, matrices, handshake timing and band completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix3_band_sequencer;

  localparam int COLS = 640;
  localparam int ROWS = 4;
  localparam int PD   = 8;
  localparam int BAND = ROWS * COLS;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [PD-1:0]  pixel = '0;
  logic           pixel_valid = 1'b0;
  logic           pixel_ready;
  logic [9:0]     buf_col;
  logic [1:0]     buf_row;
  logic [PD-1:0]  buf_pixel;
  logic           buf_we;
  logic           buf_re;
  logic [63:0]    buf_matrix = '0;
  logic [63:0]    matrix;
  logic [1:0]     mrow;
  logic [9:0]     mcol;
  logic           mvalid;
  logic           mready = 1'b1;
  logic           band_done;

  matrix3_band_sequencer #(
    .P_COLUMNS     (COLS),
    .P_ROWS        (ROWS),
    .P_PIXEL_DEPTH (PD)
  ) dut (
    .I_CLK              (clk),
    .I_RESET_N          (rst_n),
    .I_PIXEL            (pixel),
    .I_PIXEL_VALID      (pixel_valid),
    .O_PIXEL_READY      (pixel_ready),
    .O_BUF_COLUMN       (buf_col),
    .O_BUF_ROW          (buf_row),
    .O_BUF_PIXEL        (buf_pixel),
    .O_BUF_WRITE_ENABLE (buf_we),
    .O_BUF_READ_ENABLE  (buf_re),
    .I_BUF_MATRIX       (buf_matrix),
    .O_MATRIX           (matrix),
    .O_MATRIX_ROW       (mrow),
    .O_MATRIX_COLUMN    (mcol),
    .O_MATRIX_VALID     (mvalid),
    .I_MATRIX_READY     (mready),
    .O_BAND_DONE        (band_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- buffer model (environment) ----------------
  logic [PD-1:0] mem [ROWS][COLS];

  function automatic logic [PD-1:0] mem_px(input int r, input int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return '0;
    return mem[r][c];
  endfunction

  always @(posedge clk) begin
    int r;
    int c;
    r = int'(buf_row);
    c = int'(buf_col);
    if (buf_we) mem[r][c] <= buf_pixel;
    if (buf_re)
      buf_matrix <= {mem_px(r-1,c-1), mem_px(r-1,c), mem_px(r-1,c+1),
                     mem_px(r,c-1),                  mem_px(r,c+1),
                     mem_px(r+1,c-1), mem_px(r+1,c), mem_px(r+1,c+1)};
  end

  // ---------------- reference model ----------------
  int ref_pix [ROWS][COLS];

  function automatic logic [PD-1:0] ref_px(input int r, input int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return '0;
    return PD'(ref_pix[r][c]);
  endfunction

  function automatic logic [63:0] exp_mat(input int r, input int c);
    return {ref_px(r-1,c-1), ref_px(r-1,c), ref_px(r-1,c+1),
            ref_px(r,c-1),                  ref_px(r,c+1),
            ref_px(r+1,c-1), ref_px(r+1,c), ref_px(r+1,c+1)};
  endfunction

  typedef struct { int row; int col; logic [PD-1:0] pix; } wr_t;
  typedef struct { int row; int col; logic [63:0] m; } mat_t;
  wr_t  wr_q[$];
  mat_t mat_q[$];

  // ---------------- scoring ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"}, pixel_ready, 0);
    chk({tag, "_bufcol"}, buf_col, 0);
    chk({tag, "_bufrow"}, buf_row, 0);
    chk({tag, "_bufpix"}, buf_pixel, 0);
    chk({tag, "_we"}, buf_we, 0);
    chk({tag, "_re"}, buf_re, 0);
    chk({tag, "_matrix"}, matrix, 0);
    chk({tag, "_mrow"}, mrow, 0);
    chk({tag, "_mcol"}, mcol, 0);
    chk({tag, "_mvalid"}, mvalid, 0);
    chk({tag, "_done"}, band_done, 0);
  endtask

  // ---------------- monitor ----------------
  bit           mon_en = 1'b0;
  int           we_due = -1, re_due = -1, valid_due = -1, done_due = -1, rdy_low_due = -1;
  int           mon_acc = 0;
  bit           prev_valid = 1'b0, prev_ready = 1'b0;
  logic [63:0]  prev_mat = '0;
  logic [1:0]   prev_mrow = '0;
  logic [9:0]   prev_mcol = '0;

  initial begin
    wr_t  ew;
    mat_t em;
    bit   acc, hs;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        acc = pixel_valid && pixel_ready;
        hs  = mvalid && mready;

        chk("write_strobe", buf_we, cyc == we_due);
        if (buf_we) begin
          chk("write_expected", wr_q.size() != 0, 1);
          if (wr_q.size() != 0) begin
            ew = wr_q.pop_front();
            chk("write_row", buf_row, ew.row);
            chk("write_col", buf_col, ew.col);
            chk("write_pixel", buf_pixel, ew.pix);
          end
        end

        chk("read_strobe", buf_re, cyc == re_due);
        if (buf_re && mat_q.size() != 0) begin
          chk("read_row", buf_row, mat_q[0].row);
          chk("read_col", buf_col, mat_q[0].col);
        end

        chk("band_done", band_done, cyc == done_due);
        if (cyc == done_due) chk("ready_at_done", pixel_ready, 1);
        if (cyc == rdy_low_due) chk("ready_low_after_fill", pixel_ready, 0);

        if (mvalid && !prev_valid) chk("valid_latency", cyc, valid_due);

        if (prev_valid && !prev_ready) begin
          chk("hold_valid", mvalid, 1);
          chk("hold_matrix", matrix, prev_mat);
          chk("hold_row", mrow, prev_mrow);
          chk("hold_col", mcol, prev_mcol);
        end

        if (hs) begin
          chk("matrix_expected", mat_q.size() != 0, 1);
          if (mat_q.size() != 0) begin
            em = mat_q.pop_front();
            chk("matrix_value", matrix, em.m);
            chk("matrix_row", mrow, em.row);
            chk("matrix_col", mcol, em.col);
            if (em.row == ROWS-1 && em.col == COLS-1) begin
              done_due = cyc + 1;
            end else begin
              re_due    = cyc + 2;
              valid_due = cyc + 4;
            end
          end
        end

        if (acc) begin
          we_due = cyc + 1;
          if (mon_acc == BAND-1) begin
            mon_acc     = 0;
            rdy_low_due = cyc + 1;
            re_due      = cyc + 2;
            valid_due   = cyc + 4;
          end else begin
            mon_acc++;
          end
        end

        prev_valid = mvalid;
        prev_ready = mready;
        prev_mat   = matrix;
        prev_mrow  = mrow;
        prev_mcol  = mcol;
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  int rdy_mode = 0;   // 0: held high (one backpressure window), 1: random
  bit bp_done  = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        if (!bp_done && mvalid && mrow == 2'd1 && mcol == 10'd5) begin
          mready = 1'b0;
          repeat (10) @(posedge clk);
          #1;
          mready  = 1'b1;
          bp_done = 1'b1;
        end else begin
          mready = 1'b1;
        end
      end else begin
        mready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- upstream driver ----------------
  task automatic fill_band(input int count, input bit gaps, input bit rnd,
                           output int first_c, output int last_c);
    int  n = 0;
    int  guard = 0;
    bit  ph = 1'b1;
    first_c = -1;
    last_c  = -1;
    while (n < count && guard < 20000) begin
      @(posedge clk);
      #1;
      pixel_valid = gaps ? ph : 1'b1;
      ph          = ~ph;
      pixel       = rnd ? PD'($urandom) : PD'(n % 256);
      @(negedge clk);
      guard++;
      if (pixel_valid && pixel_ready) begin
        ref_pix[n / COLS][n % COLS] = int'(pixel);
        wr_q.push_back('{row: n / COLS, col: n % COLS, pix: pixel});
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        n++;
      end
    end
    chk("fill_complete", n, count);
    if (n == BAND) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mat_q.push_back('{row: r, col: c, m: exp_mat(r, c)});
    end
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!band_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("band_done_seen", band_done, 1);
    @(negedge clk);
    chk("scan_queue_drained", mat_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int f0, f1;
    int guard;

    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", pixel_ready, 1);

    // Band 1: pattern pixels, valid held high, ready high with one stall.
    rdy_mode = 0;
    fill_band(BAND, 1'b0, 1'b0, f0, f1);
    chk("fill_span_continuous", f1 - f0, BAND - 1);
    wait_done(20000);

    // Band 2: random pixels, valid every other cycle, random ready.
    rdy_mode = 1;
    fill_band(BAND, 1'b1, 1'b1, f0, f1);
    chk("fill_span_gapped", f1 - f0, 2 * (BAND - 1));
    wait_done(40000);

    // Band 3: reset in the middle of the scan.
    rdy_mode = 0;
    fill_band(BAND, 1'b0, 1'b1, f0, f1);
    guard = 0;
    while (mat_q.size() > BAND - 6 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("scan_progress_before_reset", mat_q.size() <= BAND - 6, 1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midscan_reset");
    wr_q.delete();
    mat_q.delete();
    we_due = -1; re_due = -1; valid_due = -1; done_due = -1; rdy_low_due = -1;
    mon_acc = 0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("ready_after_midscan_reset", pixel_ready, 1);
    fill_band(8, 1'b0, 1'b1, f0, f1);
    repeat (4) @(negedge clk);
    chk("write_queue_drained", wr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix3_band_sequencer.md
# matrix3_band_sequencer

Control block that drives the write and read ports of the 640×4 3×3-matrix frame buffer. It accepts a raster pixel stream with a valid/ready handshake and writes one full 4-row band into the buffer. It then reads the 8-neighbour matrix for every pixel of that band and presents each matrix downstream, for example to the Sobel stage, with its own valid/ready handshake. The block alternates between filling a band and scanning it, one band at a time.

## Interface
- P_COLUMNS, 640, columns per band
- P_ROWS, 4, rows per band
- P_PIXEL_DEPTH, 8, bits per pixel
- I_CLK  in  1  clock; all state changes on rising edge
- I_RESET_N  in  1  asynchronous active-low reset
- I_PIXEL  in  P_PIXEL_DEPTH  upstream pixel, raster order
- I_PIXEL_VALID  in  1  upstream pixel valid
- O_PIXEL_READY  out  1  block accepts a pixel this cycle
- O_BUF_COLUMN  out  clog2(P_COLUMNS)  buffer column address
- O_BUF_ROW  out  clog2(P_ROWS)  buffer row address
- O_BUF_PIXEL  out  P_PIXEL_DEPTH  buffer write data
- O_BUF_WRITE_ENABLE  out  1  buffer write strobe
- O_BUF_READ_ENABLE  out  1  buffer read strobe
- I_BUF_MATRIX  in  8*P_PIXEL_DEPTH  buffer matrix output {TL,T,TR,ML,MR,BL,B,BR}
- O_MATRIX  out  8*P_PIXEL_DEPTH  registered matrix for downstream
- O_MATRIX_ROW  out  clog2(P_ROWS)  center row of O_MATRIX
- O_MATRIX_COLUMN  out  clog2(P_COLUMNS)  center column of O_MATRIX
- O_MATRIX_VALID  out  1  O_MATRIX valid
- I_MATRIX_READY  in  1  downstream accepts O_MATRIX
- O_BAND_DONE  out  1  one-cycle pulse when the last matrix of a band is accepted

## Operation
- All outputs are registered. Reset (asynchronous, immediate) sets every output to 0, the state to FILL, and the write and scan pointers to (0,0).
- **States:** FILL, RD_ISSUE, RD_WAIT, RD_LATCH, HOLD.
- **FILL**
  - O_PIXEL_READY=1 (set on the first edge after reset release, or on re-entry).
  - On each edge where I_PIXEL_VALID & O_PIXEL_READY: drive the next-cycle bus as WRITE_ENABLE=1, READ_ENABLE=0, PIXEL=I_PIXEL, ROW/COLUMN = write pointer.
  - Advance the pointer: column+1; at P_COLUMNS-1 wrap the column to 0 and increment the row.
  - With no accept, WRITE_ENABLE=0 next cycle and the pointer holds.
  - Accepting pixel (P_ROWS-1, P_COLUMNS-1): O_PIXEL_READY←0, write pointer←(0,0), go to RD_ISSUE.
- **RD_ISSUE:** next-cycle bus = READ_ENABLE=1, WRITE_ENABLE=0, ROW/COLUMN = scan pointer. Go to RD_WAIT.
- **RD_WAIT:** READ_ENABLE←0; the buffer captures the matrix this cycle. Go to RD_LATCH.
- **RD_LATCH:** O_MATRIX←I_BUF_MATRIX, O_MATRIX_ROW/COLUMN←scan pointer, O_MATRIX_VALID←1. Go to HOLD.
- **HOLD**
  - O_MATRIX, O_MATRIX_ROW and O_MATRIX_COLUMN are stable while VALID & !READY. No buffer strobes are issued.
  - On VALID & READY: O_MATRIX_VALID←0 and advance the scan pointer (same raster order).
  - If the accepted matrix was (P_ROWS-1, P_COLUMNS-1): O_BAND_DONE←1 for one cycle, O_PIXEL_READY←1, scan pointer←(0,0), go to FILL.
  - Otherwise go to RD_ISSUE.
- WRITE_ENABLE and READ_ENABLE are never both 1. Each is high for exactly one cycle per operation.
- Border zeros come from the buffer. The block passes the matrix through unaltered.
- A reset mid-band abandons that band. The next fill rewrites every location, so no buffer clear is needed.

## Timing
- **Write path:** accept at edge t → buffer write strobe during cycle t+1 → data stored at the end of t+1.
- **Fill duration:** P_COLUMNS·P_ROWS = 2560 accepts minimum (one per cycle with valid held high).
- **Fill-to-scan gap:** the last write strobe and the first read strobe are in consecutive cycles.
- **Read latency:** RD_ISSUE at cycle h+1 → READ_ENABLE in h+2 → O_MATRIX_VALID from h+4, where h is the previous handshake cycle.
- **Throughput:** one matrix per 4 cycles with I_MATRIX_READY held high, i.e. 10240 scan cycles per band.
- **O_BAND_DONE** is asserted in the cycle after the final handshake, coincident with O_PIXEL_READY returning to 1.

## Test plan
- **Reset:** drive I_RESET_N=0 mid-scan → all outputs 0 without waiting for a clock edge. After release, O_PIXEL_READY=1 after one edge and the first write goes to (0,0).
- **Fill:** stream pixel = (row·640+col) mod 256 with valid held high → 2560 consecutive write strobes with raster coordinates, no read strobe. O_PIXEL_READY=0 after the 2560th accept, then READ_ENABLE at (0,0) 2 cycles later.
- **First matrix:** with the fill above, O_MATRIX at (0,0) = {0,0,0,0,1,0,128,129}. At (1,1) = {0,1,2,128,130,0,1,2} (row 2 col 0 = 1280 mod 256 = 0). Valid spacing is 4 cycles with ready held high.
- **Backpressure:** hold I_MATRIX_READY=0 for 10 cycles at (1,5) → O_MATRIX, ROW and COLUMN are unchanged and no buffer strobe is issued. Releasing ready causes the next read at (1,6).
- **Upstream gaps:** toggle I_PIXEL_VALID every other cycle → a write strobe only after valid cycles, the pointer holds otherwise, and the fill takes 5120 cycles.
- **Band end:** on the handshake at (3,639), O_BAND_DONE pulses for 1 cycle and O_PIXEL_READY=1. A second band fill then starts at (0,0) and the scan repeats correctly.
